scan_index_gen: RTL

//  Upstream stage of the 3-to-8 one-hot select decoder. Generates the 3-bit

---
 rtl/scan_index_gen_pkg.sv | 46 ++++
 rtl/scan_index_gen_dwell_timer.sv | 32 +++
 rtl/scan_index_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/scan_index_gen_pkg.sv
// Shared definitions for the scan index generator and its downstream 3-to-8 decoder.
package scan_index_gen_pkg;

  localparam int SEL_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DWELL = ST_DWELL,
    DEAD  = ST_DEAD
  } scan_state_e;

  typedef struct packed {
    logic             wrap;
    logic [SEL_W-1:0] sel;
  } adv_t;

  // Next index for one advance; out-of-range indices fold back onto the wrap point.
  function automatic adv_t next_index(input logic [SEL_W-1:0] sel,
                                      input logic [SEL_W-1:0] last_idx,
                                      input logic             dir);
    adv_t r;
    r.wrap = 1'b0;
    r.sel  = sel;
    if (!dir) begin
      if (sel >= last_idx) begin
        r.sel  = '0;
        r.wrap = 1'b1;
      end else begin
        r.sel = sel + 1'b1;
      end
    end else begin
      if (sel == '0 || sel > last_idx) begin
        r.sel  = last_idx;
        r.wrap = 1'b1;
      end else begin
        r.sel = sel - 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_index_gen_dwell_timer.sv
// Loadable down-counter shared by the dwell and dead-time intervals.
module scan_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (load_i)              cnt_d = load_val_i;
    else if (en_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scan_index_gen.sv
// Scan index generator: steps a 3-bit decoder index with programmable dwell and
// blanking dead time, plus manual stepping while idle.
module scan_index_gen
  import scan_index_gen_pkg::*;
#(
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] last_idx,
  input  logic             dir,
  input  logic             step,
  output logic [SEL_W-1:0] sel,
  output logic             blank,
  output logic             wrap
);

  localparam int TMAX = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  // The timer holds the cycles still to go after the loading edge; zero marks the final one.
  localparam logic [TW-1:0] DWELL_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] DEAD_LOAD  = TW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam bit            NO_DEAD    = (DEAD_CYCLES == 0);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             blank_q, blank_d;
  logic             wrap_q, wrap_d;

  logic             tmr_clr, tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]    tmr_val;
  logic             advance;
  adv_t             nxt;

  scan_dwell_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .en_i      (tmr_dec),
    .zero_o    (tmr_zero)
  );

  assign nxt = next_index(sel_q, last_idx, dir);

  always_comb begin
    state_d  = state_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = DWELL_LOAD;
    advance  = 1'b0;

    if (!en) begin
      // Dropping en always wins, even over a timer expiring on the same edge.
      state_d = IDLE;
      tmr_clr = 1'b1;
      advance = (state_q == IDLE) && step;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = DWELL;
          tmr_load = 1'b1;
        end
        DWELL: begin
          if (!tmr_zero) begin
            tmr_dec = 1'b1;
          end else if (NO_DEAD) begin
            tmr_load = 1'b1;
            advance  = 1'b1;
          end else begin
            state_d  = DEAD;
            tmr_load = 1'b1;
            tmr_val  = DEAD_LOAD;
          end
        end
        DEAD: begin
          if (!tmr_zero) begin
            tmr_dec = 1'b1;
          end else begin
            state_d  = DWELL;
            tmr_load = 1'b1;
            advance  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end
      endcase
    end

    sel_d   = advance ? nxt.sel : sel_q;
    wrap_d  = advance && nxt.wrap;
    blank_d = (state_d != DWELL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      blank_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sel   = sel_q;
  assign blank = blank_q;
  assign wrap  = wrap_q;

endmodule
